// File: rtl/sci_pkg.sv
// Shared SCI definitions: FSM encodings for master and slave,
// line polarities, command encoding and the minimum CSN gap.
package sci_pkg;

   localparam logic SCI_CSN_IDLE = 1'b1;
   localparam logic SCI_WRITE    = 1'b1;
   localparam logic SCI_READ     = 1'b0;

   localparam int SCI_MIN_CSN_GAP = 2;

   // Master FSM encodings
   localparam logic [2:0] M_GAP   = 3'd0;
   localparam logic [2:0] M_IDLE  = 3'd1;
   localparam logic [2:0] M_CMD   = 3'd2;
   localparam logic [2:0] M_ADDR  = 3'd3;
   localparam logic [2:0] M_WDATA = 3'd4;
   localparam logic [2:0] M_WACK  = 3'd5;
   localparam logic [2:0] M_RDATA = 3'd6;
   localparam logic [2:0] M_DONE  = 3'd7;

   // Slave FSM encodings
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CMD   = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_WDATA = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_RDATA = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   function automatic int sci_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sci_master_shifter.sv
// SCI master datapath: PISO for {wnr, addr, wdata}, SIPO for read data,
// and one bit counter shared by the address, write and read phases.
// Ports: load_i/wnr_i/addr_i/wdata_i load the PISO, req_o is its MSB;
// cnt_clr_i/cnt_inc_i drive cnt_o; sample_i shifts resp_i into the SIPO,
// rd_next_o is the read word including the bit being sampled now.
module sci_master_shifter
   import sci_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic                  wnr_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  cnt_clr_i,
   input  logic                  cnt_inc_i,
   input  logic                  sample_i,
   input  logic                  resp_i,
   output logic                  req_o,
   output logic [$clog2(sci_max(ADDR_WIDTH, DATA_WIDTH)+1)-1:0] cnt_o,
   output logic [DATA_WIDTH-1:0] rd_next_o
);

   localparam int SW = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int CW = $clog2(sci_max(ADDR_WIDTH, DATA_WIDTH) + 1);

   logic [SW-1:0]         sr_q, sr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-2:0] rd_q, rd_d;

   assign rd_next_o = {rd_q, resp_i};
   assign req_o     = sr_q[SW-1];
   assign cnt_o     = cnt_q;

   // Reads load zero data so SCI_REQ idles low once the address is out.
   always_comb begin
      sr_d = {sr_q[SW-2:0], 1'b0};
      if (load_i) begin
         sr_d = {wnr_i, addr_i, wdata_i & {DATA_WIDTH{wnr_i == SCI_WRITE}}};
      end
      cnt_d = cnt_q;
      if (cnt_clr_i) begin
         cnt_d = '0;
      end else if (cnt_inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
      rd_d = sample_i ? rd_next_o[DATA_WIDTH-2:0] : rd_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sr_q  <= '0;
         cnt_q <= '0;
         rd_q  <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
         rd_q  <= rd_d;
      end
   end

endmodule

// File: rtl/sci_master.sv
// SCI master: serialises host read/write commands onto SCI_CSN/SCI_REQ
// and collects read data from SCI_RESP/SCI_ACK, with an ACK timeout.
// Ports: cmd_* host command handshake, rsp_* completion pulse/data/error,
// sci_* serial lines to the slave. All outputs are registered.
module sci_master
   import sci_pkg::*;
#(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CSN_GAP        = SCI_MIN_CSN_GAP
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_wnr_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  sci_csn_o,
   output logic                  sci_req_o,
   input  logic                  sci_resp_i,
   input  logic                  sci_ack_i
);

   localparam int CW = $clog2(sci_max(ADDR_WIDTH, DATA_WIDTH) + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(CSN_GAP + 1);

   logic [2:0]            state_q, state_d;
   logic [GW-1:0]         gap_q, gap_d;
   logic [TW-1:0]         to_q, to_d;
   logic                  wnr_q, wnr_d;
   logic                  csn_q, csn_d;
   logic                  ready_q, ready_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  accept;
   logic                  wait_st;
   logic                  to_hit;
   logic                  sample;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] rd_next;

   assign accept  = cmd_valid_i && ready_q;
   assign wait_st = (state_q == M_WACK) || (state_q == M_RDATA);
   assign to_hit  = (to_q == TW'(TIMEOUT_CYCLES - 1));
   assign sample  = (state_q == M_RDATA) && sci_ack_i;

   // Any ACK restarts the timeout window; outside the wait states it idles.
   assign to_d = (wait_st && !sci_ack_i) ? to_q + 1'b1 : '0;

   sci_master_shifter #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_shifter (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (accept),
      .wnr_i     (cmd_wnr_i),
      .addr_i    (cmd_addr_i),
      .wdata_i   (cmd_wdata_i),
      .cnt_clr_i (state_d != state_q),
      .cnt_inc_i ((state_q == M_ADDR) || (state_q == M_WDATA) || sample),
      .sample_i  (sample),
      .resp_i    (sci_resp_i),
      .req_o     (sci_req_o),
      .cnt_o     (cnt),
      .rd_next_o (rd_next)
   );

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      wnr_d   = wnr_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      unique case (state_q)
         M_GAP: begin
            gap_d = gap_q + 1'b1;
            if (gap_q == GW'(CSN_GAP - 1)) begin
               state_d = M_IDLE;
               gap_d   = '0;
            end
         end
         M_IDLE: begin
            if (accept) begin
               state_d = M_CMD;
               wnr_d   = cmd_wnr_i;
            end
         end
         M_CMD: state_d = M_ADDR;
         M_ADDR: begin
            if (cnt == CW'(ADDR_WIDTH - 1)) begin
               state_d = (wnr_q == SCI_WRITE) ? M_WDATA : M_RDATA;
            end
         end
         M_WDATA: begin
            if (cnt == CW'(DATA_WIDTH - 1)) state_d = M_WACK;
         end
         M_WACK: begin
            if (sci_ack_i) begin
               state_d = M_DONE;
               err_d   = 1'b0;
            end else if (to_hit) begin
               state_d = M_DONE;
               err_d   = 1'b1;
            end
         end
         M_RDATA: begin
            if (sci_ack_i && (cnt == CW'(DATA_WIDTH - 1))) begin
               state_d = M_DONE;
               err_d   = 1'b0;
               rdata_d = rd_next;
            end else if (!sci_ack_i && to_hit) begin
               state_d = M_DONE;
               err_d   = 1'b1;
            end
         end
         M_DONE: begin
            state_d = M_GAP;
            gap_d   = '0;
         end
         default: begin
            state_d = M_GAP;
            gap_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_q.
   always_comb begin
      csn_d   = ((state_d == M_GAP) || (state_d == M_IDLE)) ?
                SCI_CSN_IDLE : ~SCI_CSN_IDLE;
      ready_d = (state_d == M_IDLE);
      valid_d = (state_d == M_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= M_GAP;
         gap_q   <= '0;
         to_q    <= '0;
         wnr_q   <= SCI_READ;
         csn_q   <= SCI_CSN_IDLE;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         to_q    <= to_d;
         wnr_q   <= wnr_d;
         csn_q   <= csn_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign cmd_ready_o = ready_q;
   assign rsp_valid_o = valid_q;
   assign rsp_err_o   = err_q;
   assign rsp_rdata_o = rdata_q;
   assign sci_csn_o   = csn_q;

endmodule

// File: tb/tb_sci_master.sv
// Directed bench for sci_master with a behavioural SCI slave model.
// Covers write, read, timeouts, back-to-back, mid reset and stalled ACK.
module tb_sci_master;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_wnr;
   logic [7:0] cmd_addr, cmd_wdata;
   logic       rsp_valid, rsp_err;
   logic [7:0] rsp_rdata;
   logic       sci_csn, sci_req, sci_resp, sci_ack;

   int vectors = 0;
   int errors  = 0;

   logic [7:0] mem [256];

   always #5 clk = ~clk;

   sci_master #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(TO),
      .CSN_GAP(2)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_wnr_i   (cmd_wnr),
      .cmd_addr_i  (cmd_addr),
      .cmd_wdata_i (cmd_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .sci_csn_o   (sci_csn),
      .sci_req_o   (sci_req),
      .sci_resp_i  (sci_resp),
      .sci_ack_i   (sci_ack)
   );

   // One transaction: issue, capture the serial request, play the slave
   // until RSP_VALID. Returns at the negedge where RSP_VALID is high.
   // lat = cycles after the last request bit before the first ACK;
   // pat = cyclic ACK pattern (read), pat==0 means never ACK (write);
   // maxb = read bits the slave is willing to send.
   task automatic do_txn(input logic wnr, input logic [7:0] addr,
                         input logic [7:0] wdata, input int lat,
                         input logic [3:0] pat, input int maxb,
                         input bit hold,
                         output logic [16:0] bits, output int gap,
                         output int cyc, output bit tmo,
                         output bit csn_ok);
      int n, k, b, guard;
      logic [7:0] a_cap, d_cap, rd;
      bits = '0; gap = 0; cyc = 0; tmo = 1'b0; csn_ok = 1'b1;
      cmd_valid = 1'b1;
      cmd_wnr = wnr; cmd_addr = addr; cmd_wdata = wdata;
      guard = 0;
      while (cmd_ready !== 1'b1 && guard < 50) begin
         if (sci_csn === 1'b1) gap++;
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         tmo = 1'b1;
         cmd_valid = 1'b0;
         return;
      end
      if (sci_csn === 1'b1) gap++;
      @(negedge clk);
      cmd_valid = hold;
      n = wnr ? 1 + AW + DW : 1 + AW;
      for (int i = 0; i < n; i++) begin
         bits = {bits[15:0], sci_req};
         if (sci_csn !== 1'b0) csn_ok = 1'b0;
         @(negedge clk);
      end
      a_cap = wnr ? bits[15:8] : bits[7:0];
      d_cap = bits[7:0];
      rd = mem[a_cap];
      k = 0; b = 0;
      while (rsp_valid !== 1'b1 && k < 300) begin
         sci_ack = 1'b0; sci_resp = 1'b0;
         if (wnr) begin
            sci_ack = (pat != 4'd0) && (k == lat);
         end else if (k >= lat && b < maxb && pat[(k - lat) % 4]) begin
            sci_ack = 1'b1;
            sci_resp = rd[7 - b];
            b++;
         end
         @(negedge clk);
         k++;
      end
      sci_ack = 1'b0; sci_resp = 1'b0;
      cyc = k;
      if (k >= 300) tmo = 1'b1;
      else if (wnr && rsp_err === 1'b0) mem[a_cap] = d_cap;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++; if (sci_csn !== 1'b1) begin errors++; $display("FAIL rst_csn got %b want 1", sci_csn); end
      vectors++; if (sci_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", sci_req); end
      vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", cmd_ready); end
      vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", rsp_valid); end
      vectors++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", rsp_err); end
      vectors++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h want 00", rsp_rdata); end
      rst = 1'b0;
      @(negedge clk);
      vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL gap_ready got %b want 0", cmd_ready); end
      @(negedge clk);
      vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", cmd_ready); end
   endtask

   task automatic test_write;
      logic [16:0] bits;
      int gap, cyc, nv, nh;
      bit tmo, csn_ok;
      do_txn(1'b1, 8'hA5, 8'h3C, 3, 4'b1111, 8, 1'b0, bits, gap, cyc, tmo, csn_ok);
      vectors++; if (tmo !== 1'b0) begin errors++; $display("FAIL wr_bound got %b want 0", tmo); end
      vectors++; if (bits !== 17'h1A53C) begin errors++; $display("FAIL wr_bits got %h want 1a53c", bits); end
      vectors++; if (csn_ok !== 1'b1) begin errors++; $display("FAIL wr_csn_low got %b want 1", csn_ok); end
      vectors++; if (cyc !== 4) begin errors++; $display("FAIL wr_latency got %0d want 4", cyc); end
      vectors++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", rsp_err); end
      vectors++; if (mem[8'hA5] !== 8'h3C) begin errors++; $display("FAIL wr_slave_data got %h want 3c", mem[8'hA5]); end
      nv = 0; nh = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) nv++;
         if (sci_csn === 1'b1) nh++;
      end
      vectors++; if (nv !== 0) begin errors++; $display("FAIL wr_extra_valid got %0d want 0", nv); end
      vectors++; if (nh < 2) begin errors++; $display("FAIL wr_csn_gap got %0d want >=2", nh); end
      vectors++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata got %h want 00", rsp_rdata); end
   endtask

   task automatic test_read;
      logic [16:0] bits;
      int gap, cyc, nv;
      bit tmo, csn_ok;
      mem[8'h5A] = 8'hC3;
      do_txn(1'b0, 8'h5A, 8'hFF, 4, 4'b1111, 8, 1'b0, bits, gap, cyc, tmo, csn_ok);
      vectors++; if (tmo !== 1'b0) begin errors++; $display("FAIL rd_bound got %b want 0", tmo); end
      vectors++; if (bits[8:0] !== 9'h05A) begin errors++; $display("FAIL rd_bits got %h want 05a", bits[8:0]); end
      vectors++; if (rsp_rdata !== 8'hC3) begin errors++; $display("FAIL rd_data got %h want c3", rsp_rdata); end
      vectors++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", rsp_err); end
      vectors++; if (cyc !== 12) begin errors++; $display("FAIL rd_latency got %0d want 12", cyc); end
      nv = 0;
      sci_ack = 1'b1; sci_resp = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) nv++;
      end
      sci_ack = 1'b0; sci_resp = 1'b0;
      vectors++; if (nv !== 0) begin errors++; $display("FAIL rd_stray_valid got %0d want 0", nv); end
      vectors++; if (rsp_rdata !== 8'hC3) begin errors++; $display("FAIL rd_stray_data got %h want c3", rsp_rdata); end
   endtask

   task automatic test_timeout;
      logic [16:0] bits;
      int gap, cyc;
      bit tmo, csn_ok;
      do_txn(1'b1, 8'h77, 8'h11, 0, 4'b0000, 8, 1'b0, bits, gap, cyc, tmo, csn_ok);
      vectors++; if (tmo !== 1'b0) begin errors++; $display("FAIL wto_bound got %b want 0", tmo); end
      vectors++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL wto_err got %b want 1", rsp_err); end
      vectors++; if (cyc !== 16) begin errors++; $display("FAIL wto_cycles got %0d want 16", cyc); end
      vectors++; if (rsp_rdata !== 8'hC3) begin errors++; $display("FAIL wto_rdata got %h want c3", rsp_rdata); end
      @(negedge clk);
      vectors++; if (sci_csn !== 1'b1) begin errors++; $display("FAIL wto_csn got %b want 1", sci_csn); end
      mem[8'h5A] = 8'h0F;
      do_txn(1'b0, 8'h5A, 8'h00, 0, 4'b1111, 3, 1'b0, bits, gap, cyc, tmo, csn_ok);
      vectors++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL rto_err got %b want 1", rsp_err); end
      vectors++; if (cyc !== 19) begin errors++; $display("FAIL rto_cycles got %0d want 19", cyc); end
      vectors++; if (rsp_rdata !== 8'hC3) begin errors++; $display("FAIL rto_rdata got %h want c3", rsp_rdata); end
   endtask

   task automatic test_back_to_back;
      logic [16:0] bits;
      int gap, cyc;
      bit tmo, csn_ok;
      do_txn(1'b1, 8'h01, 8'h5E, 2, 4'b1111, 8, 1'b1, bits, gap, cyc, tmo, csn_ok);
      vectors++; if (bits !== 17'h1015E) begin errors++; $display("FAIL b2b_w1_bits got %h want 1015e", bits); end
      vectors++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL b2b_w1_err got %b want 0", rsp_err); end
      do_txn(1'b0, 8'h01, 8'h00, 1, 4'b1111, 8, 1'b1, bits, gap, cyc, tmo, csn_ok);
      vectors++; if (gap < 2) begin errors++; $display("FAIL b2b_gap1 got %0d want >=2", gap); end
      vectors++; if (rsp_rdata !== 8'h5E) begin errors++; $display("FAIL b2b_rd_data got %h want 5e", rsp_rdata); end
      vectors++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL b2b_rd_err got %b want 0", rsp_err); end
      do_txn(1'b1, 8'h02, 8'hA7, 0, 4'b1111, 8, 1'b0, bits, gap, cyc, tmo, csn_ok);
      vectors++; if (gap < 2) begin errors++; $display("FAIL b2b_gap2 got %0d want >=2", gap); end
      vectors++; if (tmo !== 1'b0) begin errors++; $display("FAIL b2b_w2_bound got %b want 0", tmo); end
      vectors++; if (mem[8'h02] !== 8'hA7) begin errors++; $display("FAIL b2b_w2_data got %h want a7", mem[8'h02]); end
   endtask

   task automatic test_reset_mid;
      logic [16:0] bits;
      int gap, cyc, nv, guard;
      bit tmo, csn_ok;
      cmd_valid = 1'b1; cmd_wnr = 1'b0; cmd_addr = 8'h33; cmd_wdata = 8'h00;
      guard = 0;
      while (cmd_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      vectors++; if (guard >= 50) begin errors++; $display("FAIL rm_ready_bound got %0d want <50", guard); end
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (sci_csn !== 1'b0) begin errors++; $display("FAIL rm_csn_pre got %b want 0", sci_csn); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++; if (sci_csn !== 1'b1) begin errors++; $display("FAIL rm_csn got %b want 1", sci_csn); end
      vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rm_ready got %b want 0", cmd_ready); end
      vectors++; if (sci_req !== 1'b0) begin errors++; $display("FAIL rm_req got %b want 0", sci_req); end
      vectors++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL rm_rdata got %h want 00", rsp_rdata); end
      nv = 0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid === 1'b1) nv++;
         @(negedge clk);
      end
      vectors++; if (nv !== 0) begin errors++; $display("FAIL rm_valid got %0d want 0", nv); end
      mem[8'h10] = 8'h7E;
      do_txn(1'b0, 8'h10, 8'h00, 2, 4'b1111, 8, 1'b0, bits, gap, cyc, tmo, csn_ok);
      vectors++; if (bits[8:0] !== 9'h010) begin errors++; $display("FAIL rm_rd_bits got %h want 010", bits[8:0]); end
      vectors++; if (rsp_rdata !== 8'h7E) begin errors++; $display("FAIL rm_rd_data got %h want 7e", rsp_rdata); end
      vectors++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rm_rd_err got %b want 0", rsp_err); end
   endtask

   task automatic test_stalled_read;
      logic [16:0] bits;
      int gap, cyc;
      bit tmo, csn_ok;
      mem[8'h3C] = 8'h96;
      do_txn(1'b0, 8'h3C, 8'h00, 0, 4'b0011, 8, 1'b0, bits, gap, cyc, tmo, csn_ok);
      vectors++; if (rsp_rdata !== 8'h96) begin errors++; $display("FAIL st_data got %h want 96", rsp_rdata); end
      vectors++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL st_err got %b want 0", rsp_err); end
      vectors++; if (cyc !== 14) begin errors++; $display("FAIL st_cycles got %0d want 14", cyc); end
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_wnr = 1'b0;
      cmd_addr = 8'h00; cmd_wdata = 8'h00;
      sci_ack = 1'b0; sci_resp = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_stalled_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
